mc_controller: RTL and testbench

//  Control unit for the multicycle ARM datapath: main FSM, instruction decoder and conditional-execution logic.

---
 rtl/mc_controller_pkg.sv | 61 ++++++
 rtl/mc_controller_mainfsm.sv | 117 +++++++++++
 rtl/mc_controller.sv | 150 +++++++++++++++
 tb/tb_mc_controller.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mc_controller_pkg.sv
// Shared definitions for the multicycle ARM control unit.
//   - state_t    : main FSM state encodings (4-bit)
//   - OP_*       : Instr[27:26] instruction class codes
//   - CMD_*      : data-processing cmd field codes (Instr[24:21])
//   - ALU_*      : ALUControl output codes
//   - cond_check : evaluates an ARM condition field against NZCV
package mc_controller_pkg;

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StExecR   = 4'd6,
        StExecI   = 4'd7,
        StAluWb   = 4'd8,
        StBranch  = 4'd9,
        StUnknown = 4'd10
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    // nzcv = {N, Z, C, V}; cond 4'b1111 never executes.
    function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        {n, z, c, v} = nzcv;
        case (cond)
            4'b0000: cond_check = z;
            4'b0001: cond_check = ~z;
            4'b0010: cond_check = c;
            4'b0011: cond_check = ~c;
            4'b0100: cond_check = n;
            4'b0101: cond_check = ~n;
            4'b0110: cond_check = v;
            4'b0111: cond_check = ~v;
            4'b1000: cond_check = c & ~z;
            4'b1001: cond_check = ~c | z;
            4'b1010: cond_check = (n == v);
            4'b1011: cond_check = (n != v);
            4'b1100: cond_check = ~z & (n == v);
            4'b1101: cond_check = z | (n != v);
            4'b1110: cond_check = 1'b1;
            default: cond_check = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_controller_mainfsm.sv
// Main FSM of the multicycle control unit: state register, next-state logic and
// the per-state output table. Write strobes here are unconditional; the parent
// qualifies them with the registered condition result.
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_op, i_funct_i     instruction class and immediate bit (Instr[27:25])
//   i_funct_l           load/store L bit (Instr[20])
//   o_state             current state
//   o_next_pc           PC advances unconditionally (FETCH)
//   o_branch, o_reg_w, o_mem_w  unqualified branch / register / memory writes
//   o_ir_write, o_adr_src, o_alu_src_a, o_alu_src_b, o_result_src  datapath selects
//   o_alu_op            ALU operation taken from the instruction cmd field
module mc_controller_mainfsm
    import mc_controller_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [1:0] i_op,
    input  logic       i_funct_i,
    input  logic       i_funct_l,
    output state_t     o_state,
    output logic       o_next_pc,
    output logic       o_branch,
    output logic       o_reg_w,
    output logic       o_mem_w,
    output logic       o_ir_write,
    output logic       o_adr_src,
    output logic [1:0] o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [1:0] o_result_src,
    output logic       o_alu_op
);

    state_t r_state;
    state_t w_state_next;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StFetch;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = StFetch;
        unique case (r_state)
            StFetch:  w_state_next = StDecode;
            StDecode: begin
                unique case (i_op)
                    OP_DP:   w_state_next = i_funct_i ? StExecI : StExecR;
                    OP_MEM:  w_state_next = StMemAdr;
                    OP_BR:   w_state_next = StBranch;
                    default: w_state_next = StUnknown;
                endcase
            end
            StMemAdr: w_state_next = i_funct_l ? StMemRd : StMemWr;
            StMemRd:  w_state_next = StMemWb;
            StExecR:  w_state_next = StAluWb;
            StExecI:  w_state_next = StAluWb;
            default:  w_state_next = StFetch;
        endcase
    end

    always_comb begin
        o_next_pc    = 1'b0;
        o_branch     = 1'b0;
        o_reg_w      = 1'b0;
        o_mem_w      = 1'b0;
        o_ir_write   = 1'b0;
        o_adr_src    = 1'b0;
        o_alu_src_a  = 2'b00;
        o_alu_src_b  = 2'b00;
        o_result_src = 2'b00;
        o_alu_op     = 1'b0;
        unique case (r_state)
            StFetch: begin
                o_ir_write   = 1'b1;
                o_alu_src_a  = 2'b01;
                o_alu_src_b  = 2'b10;
                o_result_src = 2'b10;
                o_next_pc    = 1'b1;
            end
            StDecode: begin
                // PC+8 is formed here so that R15 reads return it.
                o_alu_src_a  = 2'b01;
                o_alu_src_b  = 2'b10;
                o_result_src = 2'b10;
            end
            StMemAdr: o_alu_src_b = 2'b01;
            StMemRd:  o_adr_src = 1'b1;
            StMemWb: begin
                o_result_src = 2'b01;
                o_reg_w      = 1'b1;
            end
            StMemWr: begin
                o_adr_src = 1'b1;
                o_mem_w   = 1'b1;
            end
            StExecR:  o_alu_op = 1'b1;
            StExecI: begin
                o_alu_src_b = 2'b01;
                o_alu_op    = 1'b1;
            end
            StAluWb:  o_reg_w = 1'b1;
            StBranch: begin
                o_alu_src_b  = 2'b01;
                o_result_src = 2'b10;
                o_branch     = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_state = r_state;

endmodule

// File: rtl/mc_controller.sv
// Control unit for the multicycle ARM datapath: main FSM (sub-module),
// instruction decoder, condition check and NZCV flag register.
// Optional feature: define MC_CONTROLLER_PERF_EN to add the PERF_W parameter
// and the cycle_cnt / instr_cnt performance counter ports.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   Instr[19:0]         Instr[31:12] from the instruction register
//   ALUFlags            {N,Z,C,V} from the ALU this cycle
//   PCWrite, MemWrite, RegWrite, IRWrite   write enables (forced low in reset)
//   AdrSrc, RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl  datapath selects
//   cycle_cnt, instr_cnt                   performance counters (optional)
module mc_controller
    import mc_controller_pkg::*;
`ifdef MC_CONTROLLER_PERF_EN
#(
    parameter int unsigned PERF_W = 32
)
`endif
(
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  ALUControl
`ifdef MC_CONTROLLER_PERF_EN
    ,
    output logic [PERF_W-1:0] cycle_cnt,
    output logic [PERF_W-1:0] instr_cnt
`endif
);

    // Instr carries bits [31:12]; field offsets below are shifted by 12.
    logic [3:0] w_cond;
    logic [1:0] w_op;
    logic       w_funct_i;
    logic [3:0] w_cmd;
    logic       w_s;
    logic [3:0] w_rd;
    logic       w_unused_rn;

    assign w_cond      = Instr[19:16];
    assign w_op        = Instr[15:14];
    assign w_funct_i   = Instr[13];
    assign w_cmd       = Instr[12:9];
    assign w_s         = Instr[8];
    assign w_rd        = Instr[3:0];
    assign w_unused_rn = ^Instr[7:4];

    state_t     w_state;
    logic       w_next_pc, w_branch, w_reg_w, w_mem_w, w_ir_write, w_alu_op;
    logic [1:0] w_flag_w;
    logic       w_condex;
    logic       w_pcs;
    logic [3:0] r_flags;
    logic       r_condex;

    mc_controller_mainfsm u_mainfsm (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_op         (w_op),
        .i_funct_i    (w_funct_i),
        .i_funct_l    (w_s),
        .o_state      (w_state),
        .o_next_pc    (w_next_pc),
        .o_branch     (w_branch),
        .o_reg_w      (w_reg_w),
        .o_mem_w      (w_mem_w),
        .o_ir_write   (w_ir_write),
        .o_adr_src    (AdrSrc),
        .o_alu_src_a  (ALUSrcA),
        .o_alu_src_b  (ALUSrcB),
        .o_result_src (ResultSrc),
        .o_alu_op     (w_alu_op)
    );

    // ALU decode; flag-write is only ever non-zero in EXECR/EXECI.
    always_comb begin
        ALUControl = ALU_ADD;
        w_flag_w   = 2'b00;
        if (w_alu_op) begin
            case (w_cmd)
                CMD_ADD: begin ALUControl = ALU_ADD; w_flag_w = {w_s, w_s};  end
                CMD_SUB: begin ALUControl = ALU_SUB; w_flag_w = {w_s, w_s};  end
                CMD_AND: begin ALUControl = ALU_AND; w_flag_w = {w_s, 1'b0}; end
                CMD_ORR: begin ALUControl = ALU_ORR; w_flag_w = {w_s, 1'b0}; end
                default: begin ALUControl = ALU_ADD; w_flag_w = 2'b00;       end
            endcase
        end
    end

    assign RegSrc   = {w_op == OP_MEM, w_op == OP_BR};
    assign ImmSrc   = w_op;
    assign w_condex = cond_check(w_cond, r_flags);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags  <= 4'b0000;
            r_condex <= 1'b0;
        end else begin
            if (w_state == StDecode) begin
                r_condex <= w_condex;
            end
            if (w_flag_w[1] & r_condex) begin
                r_flags[3:2] <= ALUFlags[3:2];
            end
            if (w_flag_w[0] & r_condex) begin
                r_flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

    // A register write to R15 is a PC write.
    assign w_pcs    = w_branch | (w_reg_w & (w_rd == 4'd15));
    assign PCWrite  = ~reset & (w_next_pc | (w_pcs & r_condex));
    assign RegWrite = ~reset & w_reg_w & r_condex;
    assign MemWrite = ~reset & w_mem_w & r_condex;
    assign IRWrite  = ~reset & w_ir_write;

`ifdef MC_CONTROLLER_PERF_EN
    logic [PERF_W-1:0] r_cycle_cnt;
    logic [PERF_W-1:0] r_instr_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 1'b1;
            // FETCH always advances to DECODE outside reset.
            if (w_state == StFetch) begin
                r_instr_cnt <= r_instr_cnt + 1'b1;
            end
        end
    end

    assign cycle_cnt = r_cycle_cnt;
    assign instr_cnt = r_instr_cnt;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller. Each instruction pushes one expected
// output vector per cycle (plus the inputs to drive in that cycle) into a
// scoreboard queue; the drain loop applies inputs and compares every cycle.
module tb_mc_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [19:0] Instr = '0;
    logic [3:0]  ALUFlags = '0;
    logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
    logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .RegSrc     (RegSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl)
    );

    always #5 clk = ~clk;

    // {PCWrite,MemWrite,RegWrite,IRWrite,AdrSrc,RegSrc,ALUSrcA,ALUSrcB,ResultSrc,ImmSrc,ALUControl}
    logic [16:0] obs;
    assign obs = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA, ALUSrcB,
                  ResultSrc, ImmSrc, ALUControl};

    localparam logic [16:0] MaskAll = 17'h1FFFF;
    localparam logic [16:0] MaskEn  = 17'h1E000;

    typedef struct {
        logic        rst;
        logic [19:0] instr;
        logic [3:0]  flags;
        logic [16:0] mask;
        logic [16:0] exp;
        string       tag;
    } item_t;

    item_t sb_q[$];
    int    n_checks = 0;
    int    n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %05h expected %05h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] ev(input logic [19:0] i20, input logic pcw, input logic memw,
                                       input logic regw, input logic irw, input logic adr,
                                       input logic [1:0] srca, input logic [1:0] srcb,
                                       input logic [1:0] res, input logic [1:0] alu);
        logic [1:0] op;
        op = i20[15:14];
        return {pcw, memw, regw, irw, adr, op == 2'b01, op == 2'b10, srca, srcb, res, op, alu};
    endfunction

    task automatic push(input logic rst, input logic [19:0] i20, input logic [3:0] fl,
                        input logic [16:0] mask, input logic [16:0] exp, input string tag);
        item_t it;
        it.rst = rst; it.instr = i20; it.flags = fl; it.mask = mask; it.exp = exp; it.tag = tag;
        sb_q.push_back(it);
    endtask

    // Reference sequence for one instruction. fl drives ALUFlags in the execute
    // cycle (all other cycles see 4'hF, which must never be latched); ce is the
    // expected condition outcome.
    task automatic push_instr(input logic [31:0] ins, input logic [3:0] fl, input logic ce,
                              input string name);
        logic [19:0] i;
        logic [1:0]  alu, srcb;
        logic        pc_wb;
        i = ins[31:12];
        case (i[12:9])
            4'b0100: alu = 2'b00;
            4'b0010: alu = 2'b01;
            4'b0000: alu = 2'b10;
            4'b1100: alu = 2'b11;
            default: alu = 2'b00;
        endcase
        srcb  = i[13] ? 2'b01 : 2'b00;
        pc_wb = ce & (i[3:0] == 4'hF);
        push(0, i, 4'hF, MaskAll, ev(i, 1, 0, 0, 1, 0, 2'b01, 2'b10, 2'b10, 2'b00),
             {name, "/fetch"});
        push(0, i, 4'hF, MaskAll, ev(i, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b10, 2'b00),
             {name, "/decode"});
        case (i[15:14])
            2'b00: begin
                push(0, i, fl, MaskAll, ev(i, 0, 0, 0, 0, 0, 2'b00, srcb, 2'b00, alu),
                     {name, "/exec"});
                push(0, i, 4'hF, MaskAll, ev(i, pc_wb, 0, ce, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00),
                     {name, "/aluwb"});
            end
            2'b01: begin
                push(0, i, 4'hF, MaskAll, ev(i, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00),
                     {name, "/memadr"});
                if (i[8]) begin
                    push(0, i, 4'hF, MaskAll, ev(i, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00),
                         {name, "/memrd"});
                    push(0, i, 4'hF, MaskAll, ev(i, pc_wb, 0, ce, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00),
                         {name, "/memwb"});
                end else begin
                    push(0, i, 4'hF, MaskAll, ev(i, 0, ce, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00),
                         {name, "/memwr"});
                end
            end
            2'b10: push(0, i, 4'hF, MaskAll, ev(i, ce, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00),
                        {name, "/branch"});
            default: push(0, i, 4'hF, MaskAll, ev(i, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00),
                          {name, "/unknown"});
        endcase
    endtask

    task automatic drain();
        item_t it;
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            @(negedge clk);
            reset    = it.rst;
            Instr    = it.instr;
            ALUFlags = it.flags;
            #1;
            check_eq(it.tag, {15'b0, obs & it.mask}, {15'b0, it.exp & it.mask});
        end
    endtask

    initial begin
        logic [19:0] ldr;
        ldr = 20'hE5904;

        push(1, 20'h0, 4'h0, MaskEn, 17'h0, "reset/c0");
        push(1, 20'h0, 4'h0, MaskEn, 17'h0, "reset/c1");
        drain();

        push_instr(32'hE0821003, 4'h0, 1'b1, "add");       drain();
        push_instr(32'hE0510001, 4'h4, 1'b1, "subs_z1");   drain();
        push_instr(32'h00821003, 4'h0, 1'b1, "addeq_t");   drain();
        push_instr(32'hE0510001, 4'h0, 1'b1, "subs_z0");   drain();
        push_instr(32'h00821003, 4'h0, 1'b0, "addeq_f");   drain();
        push_instr(32'hE0921003, 4'h2, 1'b1, "adds_c1");   drain();
        push_instr(32'hE1921003, 4'h8, 1'b1, "orrs_n1");   drain();
        push_instr(32'h20821003, 4'h0, 1'b1, "addcs");     drain();
        push_instr(32'hE0321003, 4'h0, 1'b1, "eors_nf");   drain();
        push_instr(32'h40821003, 4'h0, 1'b1, "addmi");     drain();
        push_instr(32'h00821003, 4'h0, 1'b0, "addeq_f2");  drain();
        push_instr(32'hE2821003, 4'h0, 1'b1, "addi");      drain();
        push_instr(32'hE0021003, 4'h0, 1'b1, "and");       drain();
        push_instr(32'hE082F003, 4'h0, 1'b1, "add_pc");    drain();
        push_instr(32'hE5904008, 4'h0, 1'b1, "ldr");       drain();
        push_instr(32'hE5804004, 4'h0, 1'b1, "str");       drain();
        push_instr(32'hEA000001, 4'h0, 1'b1, "b");         drain();
        push_instr(32'hFC000000, 4'h0, 1'b0, "unknown");   drain();

        // LDR interrupted by a two-cycle reset starting in MEMRD.
        push(0, ldr, 4'hF, MaskAll, ev(ldr, 1, 0, 0, 1, 0, 2'b01, 2'b10, 2'b10, 2'b00),
             "ldr_rst/fetch");
        push(0, ldr, 4'hF, MaskAll, ev(ldr, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b10, 2'b00),
             "ldr_rst/decode");
        push(0, ldr, 4'hF, MaskAll, ev(ldr, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00),
             "ldr_rst/memadr");
        push(1, ldr, 4'hF, MaskEn, 17'h0, "ldr_rst/memrd");
        push(1, ldr, 4'hF, MaskEn, 17'h0, "ldr_rst/hold");
        drain();
        push_instr(32'hEA000001, 4'h0, 1'b1, "b_after_rst"); drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
